// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Step counter must hold STEPS-1; a single-step build still needs one bit.
  function automatic int cnt_width(input int steps);
    return (steps <= 1) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/serial_sub_full_sub_cell.sv
// Combinational 1-bit full-subtractor cell: d = x - y - bi, bo = borrow out.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub.sv
// Multi-cycle WIDTH-bit subtractor (dif = a - b - b_in), SLICE bits per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dif,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bor
);

  localparam int STEPS = WIDTH / SLICE;
  localparam int CW    = cnt_width(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic [SLICE:0]   chain;
  logic [SLICE-1:0] slice_d;
  logic [WIDTH-1:0] res_next;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  assign chain[0] = brw;

  for (genvar i = 0; i < SLICE; i++) begin : g_cell
    full_sub_cell u_cell (
      .x (a_sh[i]),
      .y (b_sh[i]),
      .bi(chain[i]),
      .d (slice_d[i]),
      .bo(chain[i+1])
    );
  end

  // The minuend register doubles as the result register: consumed low bits are
  // refilled from the top with result bits, so after STEPS shifts it holds dif.
  if (SLICE == WIDTH) begin : g_full
    assign res_next = slice_d;
  end else begin : g_part
    assign res_next = {slice_d, a_sh[WIDTH-1:SLICE]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dif   <= '0;
      bor   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= b_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end
        end
        ST_RUN: begin
          a_sh <= res_next;
          b_sh <= b_sh >> SLICE;
          brw  <= chain[SLICE];
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= ST_DONE;
            done  <= 1'b1;
            dif   <= res_next;
            bor   <= chain[SLICE];
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
`endif
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub: one SLICE=1 and one SLICE=4 instance driven in parallel.
// Optional ovf checks are compiled when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       b_in;

  logic       busy1, done1, bor1, ovf1;
  logic [7:0] dif1;
  logic       busy4, done4, bor4, ovf4;
  logic [7:0] dif4;

  int n_cmp = 0;
  int n_bad = 0;

  serial_sub #(.WIDTH(8), .SLICE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .b_in(b_in),
    .busy(busy1), .done(done1), .dif(dif1),
`ifdef SERIAL_SUB_OVF_EN
    .ovf(ovf1),
`endif
    .bor(bor1)
  );

  serial_sub #(.WIDTH(8), .SLICE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .b_in(b_in),
    .busy(busy4), .done(done4), .dif(dif4),
`ifdef SERIAL_SUB_OVF_EN
    .ovf(ovf4),
`endif
    .bor(bor4)
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf1 = 1'b0;
  assign ovf4 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] dif;
    logic       bor;
    logic       ovf;
  } vec_t;

  vec_t vecs[11];

  // Per-operation observations, filled by applyStimulus.
  int         lat1, lat4, nd1, nd4, nb1, nb4, hold_bad1, hold_bad4;
  logic [7:0] cap_dif1, cap_dif4;
  logic       cap_bor1, cap_bor4, cap_ovf1, cap_ovf4;
  logic [7:0] last_exp1, last_exp4;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Runs one operation; optionally raises start again (with ga/gb) so it is sampled at edge T(gcyc).
  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                               input logic [7:0] ga, input logic [7:0] gb, input int gcyc);
    logic [7:0] prev1, prev4;
    @(negedge clk);
    a = ta; b = tb_v; b_in = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb_v; b_in = ~tbin;
    lat1 = -1; lat4 = -1; nd1 = 0; nd4 = 0; hold_bad1 = 0; hold_bad4 = 0;
    nb1 = busy1 ? 1 : 0;
    nb4 = busy4 ? 1 : 0;
    prev1 = last_exp1;
    prev4 = last_exp4;
    cap_dif1 = 8'hxx; cap_dif4 = 8'hxx;
    cap_bor1 = 1'bx; cap_bor4 = 1'bx; cap_ovf1 = 1'bx; cap_ovf4 = 1'bx;
    for (int k = 1; k <= 24; k++) begin
      if (k == gcyc) begin
        a = ga; b = gb; start = 1'b1;
      end
      @(negedge clk);
      if (k == gcyc) start = 1'b0;
      if (busy1) nb1++;
      if (busy4) nb4++;
      if (!done1 && dif1 !== prev1) hold_bad1++;
      if (!done4 && dif4 !== prev4) hold_bad4++;
      prev1 = dif1;
      prev4 = dif4;
      if (done1) begin
        nd1++;
        if (lat1 < 0) lat1 = k;
        cap_dif1 = dif1; cap_bor1 = bor1; cap_ovf1 = ovf1;
      end
      if (done4) begin
        nd4++;
        if (lat4 < 0) lat4 = k;
        cap_dif4 = dif4; cap_bor4 = bor4; cap_ovf4 = ovf4;
      end
    end
  endtask

  // Standard checks for an uninterrupted operation on both instances.
  task automatic checkOp(input string tag, input logic [7:0] ed, input logic eb, input logic eo);
    checkOutput({tag, " dif s1"}, cap_dif1, ed);
    checkOutput({tag, " bor s1"}, cap_bor1, eb);
    checkOutput({tag, " lat s1"}, lat1, 8);
    checkOutput({tag, " ndone s1"}, nd1, 1);
    checkOutput({tag, " busy s1"}, nb1, 9);
    checkOutput({tag, " hold s1"}, hold_bad1, 0);
    checkOutput({tag, " dif s4"}, cap_dif4, ed);
    checkOutput({tag, " bor s4"}, cap_bor4, eb);
    checkOutput({tag, " lat s4"}, lat4, 2);
    checkOutput({tag, " ndone s4"}, nd4, 1);
    checkOutput({tag, " busy s4"}, nb4, 3);
    checkOutput({tag, " hold s4"}, hold_bad4, 0);
    checkOutput({tag, " held s1"}, dif1, ed);
`ifdef SERIAL_SUB_OVF_EN
    checkOutput({tag, " ovf s1"}, cap_ovf1, eo);
    checkOutput({tag, " ovf s4"}, cap_ovf4, eo);
`else
    if (eo === 1'bx) $display("[TB] note: unknown ovf expectation for %s", tag);
`endif
    last_exp1 = ed;
    last_exp4 = ed;
  endtask

  initial begin
    vecs[0]  = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1]  = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2]  = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4]  = '{8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0};
    vecs[5]  = '{8'h3C, 8'h4D, 1'b0, 8'hEF, 1'b1, 1'b0};
    vecs[6]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7]  = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[8]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};
    vecs[10] = '{8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; b_in = 1'b0;
    last_exp1 = 8'h00; last_exp4 = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", busy1, 0);
    checkOutput("reset done", done1, 0);
    checkOutput("reset dif", dif1, 8'h00);
    checkOutput("reset bor", bor1, 0);
    checkOutput("reset busy s4", busy4, 0);
    rst_n = 1'b1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, 8'h00, 8'h00, -1);
      checkOp($sformatf("vec%0d", i), vecs[i].dif, vecs[i].bor, vecs[i].ovf);
    end

    // Second start while slice-1 unit is running: ignored there, but the
    // slice-4 unit is back in IDLE by edge T4 and takes it (a=FF,b=00,b_in=1).
    $display("[TB] start during RUN");
    applyStimulus(8'h05, 8'h03, 1'b0, 8'hFF, 8'h00, 4);
    checkOutput("ign dif s1", cap_dif1, 8'h02);
    checkOutput("ign ndone s1", nd1, 1);
    checkOutput("ign lat s1", lat1, 8);
    checkOutput("ign ndone s4", nd4, 2);
    checkOutput("ign dif s4", cap_dif4, 8'hFE);
    checkOutput("ign bor s4", cap_bor4, 0);
    last_exp1 = 8'h02;
    last_exp4 = 8'hFE;

    $display("[TB] reset mid-RUN");
    @(negedge clk);
    a = 8'h05; b = 8'h03; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("pre-rst busy s1", busy1, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst busy s1", busy1, 0);
    checkOutput("rst dif s1", dif1, 8'h00);
    checkOutput("rst bor s1", bor1, 0);
    checkOutput("rst done s1", done1, 0);
    checkOutput("rst dif s4", dif4, 8'h00);
    nd1 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done1 || busy1) nd1++;
    end
    checkOutput("rst no done", nd1, 0);
    last_exp1 = 8'h00;
    last_exp4 = 8'h00;
    applyStimulus(8'h09, 8'h04, 1'b0, 8'h00, 8'h00, -1);
    checkOp("post-rst", 8'h05, 1'b0, 1'b0);

    $display("[TB] random operands");
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb, ed;
      logic       rbin, eb, eo;
      logic [8:0] full;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      full = {1'b0, ra} - {1'b0, rb} - {8'h00, rbin};
      ed = full[7:0];
      eb = full[8];
      eo = (ra[7] != rb[7]) && (ed[7] != ra[7]);
      applyStimulus(ra, rb, rbin, 8'h00, 8'h00, -1);
      checkOp($sformatf("rnd%0d", i), ed, eb, eo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
